// File: rtl/arbitro_mux_4x1_16b.sv
// Round-robin arbiter for four requesters driving a shared 4x1 data mux.
// Grants carry a bounded hold time so a busy requester cannot starve the others.
module arbitro_mux_4x1_16b #(
  parameter int LARGURA   = 16,
  parameter int MAX_POSSE = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [3:0]         requisicao,
  input  logic [LARGURA-1:0] entrada_0,
  input  logic [LARGURA-1:0] entrada_1,
  input  logic [LARGURA-1:0] entrada_2,
  input  logic [LARGURA-1:0] entrada_3,
  output logic [3:0]         concessao,
  output logic [1:0]         controle_mux,
  output logic [LARGURA-1:0] saida,
  output logic               saida_valida
);

  typedef enum logic {
    OCIOSO    = 1'b0,
    CONCEDIDO = 1'b1
  } estado_t;

  estado_t     estado_r;
  estado_t     estado_prox_s;
  logic [1:0]  ultimo_r;
  logic [1:0]  ultimo_prox_s;
  logic [7:0]  contador_r;
  logic [7:0]  contador_prox_s;
  logic [3:0]  concessao_prox_s;
  logic [1:0]  controle_prox_s;
  logic [1:0]  vencedor_s;
  logic        liberar_s;

  // Search starts just after the last winner and ends on it, so a lone holder is re-granted.
  function automatic logic [1:0] buscar_vencedor(input logic [3:0] req, input logic [1:0] ultimo);
    logic [1:0] idx;
    logic [1:0] venc;
    logic       achou;
    venc  = ultimo;
    achou = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ultimo + 2'(k);
      if (!achou && req[idx]) begin
        venc  = idx;
        achou = 1'b1;
      end
    end
    return venc;
  endfunction

  assign vencedor_s   = buscar_vencedor(requisicao, ultimo_r);
  assign liberar_s    = (requisicao[controle_mux] == 1'b0) || (contador_r == 8'(MAX_POSSE - 1));
  assign saida_valida = (estado_r == CONCEDIDO);

  // Next-state and next-grant decision.
  always_comb begin
    estado_prox_s    = estado_r;
    ultimo_prox_s    = ultimo_r;
    contador_prox_s  = contador_r;
    concessao_prox_s = concessao;
    controle_prox_s  = controle_mux;
    case (estado_r)
      OCIOSO: begin
        if (requisicao != 4'b0000) begin
          estado_prox_s    = CONCEDIDO;
          concessao_prox_s = 4'b0001 << vencedor_s;
          controle_prox_s  = vencedor_s;
          ultimo_prox_s    = vencedor_s;
          contador_prox_s  = 8'd0;
        end else begin
          estado_prox_s    = OCIOSO;
        end
      end
      CONCEDIDO: begin
        if (!liberar_s) begin
          contador_prox_s  = contador_r + 8'd1;
        end else if (requisicao != 4'b0000) begin
          estado_prox_s    = CONCEDIDO;
          concessao_prox_s = 4'b0001 << vencedor_s;
          controle_prox_s  = vencedor_s;
          ultimo_prox_s    = vencedor_s;
          contador_prox_s  = 8'd0;
        end else begin
          // Mux select keeps its last value while idle.
          estado_prox_s    = OCIOSO;
          concessao_prox_s = 4'b0000;
        end
      end
      default: begin
        estado_prox_s    = OCIOSO;
        concessao_prox_s = 4'b0000;
      end
    endcase
  end

  // State, pointer, hold counter and registered grant outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_r     <= OCIOSO;
      ultimo_r     <= 2'b11;
      contador_r   <= 8'd0;
      concessao    <= 4'b0000;
      controle_mux <= 2'b00;
    end else begin
      estado_r     <= estado_prox_s;
      ultimo_r     <= ultimo_prox_s;
      contador_r   <= contador_prox_s;
      concessao    <= concessao_prox_s;
      controle_mux <= controle_prox_s;
    end
  end

  // Data path follows the granted input combinationally.
  always_comb begin
    saida = {LARGURA{1'b0}};
    if (saida_valida) begin
      case (controle_mux)
        2'd0:    saida = entrada_0;
        2'd1:    saida = entrada_1;
        2'd2:    saida = entrada_2;
        2'd3:    saida = entrada_3;
        default: saida = {LARGURA{1'b0}};
      endcase
    end else begin
      saida = {LARGURA{1'b0}};
    end
  end

endmodule

// File: tb/tb_arbitro_mux_4x1_16b.sv
// Scoreboard bench for arbitro_mux_4x1_16b: directed scenarios then random traffic,
// checked against an integer-level round-robin model.
module tb_arbitro_mux_4x1_16b;
  localparam int LARGURA   = 16;
  localparam int MAX_POSSE = 8;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic [3:0]         requisicao = 4'b0000;
  logic [LARGURA-1:0] entrada_0 = 16'h0000;
  logic [LARGURA-1:0] entrada_1 = 16'h0000;
  logic [LARGURA-1:0] entrada_2 = 16'h0000;
  logic [LARGURA-1:0] entrada_3 = 16'h0000;
  logic [3:0]         concessao;
  logic [1:0]         controle_mux;
  logic [LARGURA-1:0] saida;
  logic               saida_valida;

  arbitro_mux_4x1_16b #(.LARGURA(LARGURA), .MAX_POSSE(MAX_POSSE)) dut (
    .clock        (clock),
    .reset        (reset),
    .requisicao   (requisicao),
    .entrada_0    (entrada_0),
    .entrada_1    (entrada_1),
    .entrada_2    (entrada_2),
    .entrada_3    (entrada_3),
    .concessao    (concessao),
    .controle_mux (controle_mux),
    .saida        (saida),
    .saida_valida (saida_valida)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0]         conc;
    logic [1:0]         sel;
    logic               val;
    logic [LARGURA-1:0] dado;
  } esperado_t;

  esperado_t fila[$];
  int total  = 0;
  int passed = 0;

  // Reference model: who holds the grant, who won last, how many cycles held so far.
  int         dono  = -1;
  int         ultimo = 3;
  int         posse = 0;
  logic [1:0] sel_m = 2'd0;

  task automatic passo(input logic r, input logic [3:0] q,
                       input logic [15:0] d0, input logic [15:0] d1,
                       input logic [15:0] d2, input logic [15:0] d3);
    logic [15:0] d[4];
    esperado_t   e;
    int          w;
    bit          liberar;
    @(negedge clock);
    reset      = r;
    requisicao = q;
    entrada_0  = d0;
    entrada_1  = d1;
    entrada_2  = d2;
    entrada_3  = d3;
    @(posedge clock);
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    if (r) begin
      dono = -1; ultimo = 3; posse = 0; sel_m = 2'd0;
    end else begin
      liberar = (dono < 0) || (q[dono] == 1'b0) || (posse == MAX_POSSE);
      if (!liberar) begin
        posse++;
      end else if (q != 4'b0000) begin
        w = -1;
        for (int k = 1; k <= 4; k++)
          if (w < 0 && q[(ultimo + k) % 4]) w = (ultimo + k) % 4;
        dono = w; ultimo = w; sel_m = 2'(w); posse = 1;
      end else begin
        dono = -1;
      end
    end
    e.val  = (dono >= 0);
    e.conc = e.val ? (4'b0001 << dono) : 4'b0000;
    e.sel  = sel_m;
    e.dado = e.val ? d[sel_m] : 16'h0000;
    fila.push_back(e);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  initial begin
    esperado_t e;
    forever begin
      @(posedge clock);
      #1;
      if (fila.size() > 0) begin
        e = fila.pop_front();
        total++;
        if (concessao === e.conc && controle_mux === e.sel &&
            saida_valida === e.val && saida === e.dado) passed++;
        else $display("FAIL saida_arbitro t=%0t: got conc=%b sel=%0d val=%b saida=%h, expected conc=%b sel=%0d val=%b saida=%h",
                      $time, concessao, controle_mux, saida_valida, saida, e.conc, e.sel, e.val, e.dado);
        total++;
        if ($onehot0(concessao)) passed++;
        else $display("FAIL onehot0 t=%0t: got conc=%b, expected at most one bit set", $time, concessao);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] q;
    logic       r;
    passo(1'b1, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    passo(1'b1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    // Basic grant, then handover without an idle cycle.
    passo(1'b0, 4'b0101, 16'h00AA, 16'h0000, 16'h00CC, 16'h0000);
    passo(1'b0, 4'b0100, 16'h00AA, 16'h0000, 16'h00CC, 16'h0000);
    passo(1'b0, 4'b0100, 16'h00AA, 16'h0000, 16'h00CD, 16'h0000);
    // All requesting: rotation with bounded hold.
    for (int i = 0; i < 42; i++) passo(1'b0, 4'b1111, 16'hA000, 16'hA001, 16'hA002, 16'hA003);
    // Lone requester is re-granted on timeout.
    passo(1'b1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < 20; i++) passo(1'b0, 4'b0010, 16'h0000, 16'(i), 16'h0000, 16'h0000);
    // Reset during a grant on requester 3.
    passo(1'b1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    passo(1'b0, 4'b1000, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    passo(1'b0, 4'b1000, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    passo(1'b1, 4'b1111, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    passo(1'b0, 4'b1111, 16'h0101, 16'h0202, 16'h0303, 16'h0404);
    // Holder drops with nobody else requesting.
    passo(1'b0, 4'b0001, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000);
    passo(1'b0, 4'b0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000);
    passo(1'b0, 4'b0000, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000);
    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      r = ($urandom_range(0, 49) == 0);
      q = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      passo(r, q, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    repeat (3) @(posedge clock);
    #2;
    total++;
    if (fila.size() == 0) passed++;
    else $display("FAIL fila_vazia: got %0d pending, expected 0", fila.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
